// File: rtl/teclado_pkg.sv
// Shared types for the key debouncer: channel FSM states and the
// synchronizer reset value (keys are active-low, so "released" is 1).
package teclado_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam logic SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/antirrebote_canal.sv
// One key channel: two-flop synchronizer, debounce FSM, auto-repeat timer.
// Press/release pulses and the debounced level are registered outputs.
module antirrebote_canal
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_FIRST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RCNT_PER   = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic       sync1_q, sync2_q;
  logic       k;
  key_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic       rep_q, rep_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  // k = 1 means the synchronized key is pressed
  assign k = ~sync2_q;

  // Bring the asynchronous raw key into the clock domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= SYNC_RESET_VAL;
      sync2_q <= SYNC_RESET_VAL;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      rep_q     <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Debounce and auto-repeat decisions; rcnt only moves while HELD sees k=1,
  // so a release bounce delays the next repeat by exactly the frozen cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (k) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!k) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          rcnt_d  = '0;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!k) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if ((!rep_q && rcnt_q == RCNT_FIRST) || (rep_q && rcnt_q == RCNT_PER)) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            rep_d   = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (k) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/teclado_antirrebote.sv
// Key conditioning front end: one independent debounce channel per key.
module teclado_antirrebote
  import teclado_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] KEYS_IN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE
);

  // One channel per key, no shared state between them
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_canal
      antirrebote_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_canal (
        .clk_i    (CLK),
        .rst_ni   (RSTn),
        .key_raw_i(KEYS_IN[gi]),
        .level_o  (KEY_LEVEL[gi]),
        .press_o  (KEY_PRESS[gi]),
        .release_o(KEY_RELEASE[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_teclado_antirrebote.sv
// Bench for teclado_antirrebote: two instances (auto-repeat on / off) share
// the stimulus; a run-length reference model feeds per-instance event queues.
module tb_teclado_antirrebote;

  localparam int D    = 4;
  localparam int RD_A = 10;
  localparam int RP   = 5;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] keys  = 2'b11;
  bit         done  = 1'b0;

  logic [1:0] lvl_a, prs_a, rel_a;
  logic [1:0] lvl_b, prs_b, rel_b;

  always #5 clk = ~clk;

  teclado_antirrebote #(
    .N_KEYS(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(RP)
  ) dut_rep (
    .CLK(clk), .RSTn(rst_n), .KEYS_IN(keys),
    .KEY_LEVEL(lvl_a), .KEY_PRESS(prs_a), .KEY_RELEASE(rel_a)
  );

  teclado_antirrebote #(
    .N_KEYS(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
  ) dut_norep (
    .CLK(clk), .RSTn(rst_n), .KEYS_IN(keys),
    .KEY_LEVEL(lvl_b), .KEY_PRESS(prs_b), .KEY_RELEASE(rel_b)
  );

  // ---------------- reference model ----------------
  // The key seen by the logic lags the raw pin by two samples. A press is
  // accepted when the pressed run reaches D+1 samples, a release likewise.
  // Repeats count pressed samples that directly follow a pressed sample.
  int  cyc = 0;
  bit  dly1 [2][2];
  bit  dly2 [2][2];
  bit  prevk[2][2];
  bit  lvl  [2][2];
  bit  first[2][2];
  int  run  [2][2];
  int  held [2][2];
  ev_t q0[$];
  ev_t q1[$];

  task automatic model_reset();
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 2; c++) begin
        dly1[u][c] = 1'b1; dly2[u][c] = 1'b1; prevk[u][c] = 1'b0;
        lvl[u][c] = 1'b0;  first[u][c] = 1'b1; run[u][c] = 0; held[u][c] = 0;
      end
  endtask

  task automatic model_step();
    logic [1:0] p, r;
    bit k;
    int rd, target;
    ev_t e;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      p = '0; r = '0;
      rd = (u == 0) ? RD_A : 0;
      for (int c = 0; c < 2; c++) begin
        k = ~dly2[u][c];
        dly2[u][c] = dly1[u][c];
        dly1[u][c] = keys[c];
        run[u][c] = (k == prevk[u][c]) ? run[u][c] + 1 : 1;
        if (!lvl[u][c] && k && run[u][c] == D + 1) begin
          p[c] = 1'b1; lvl[u][c] = 1'b1; held[u][c] = 0; first[u][c] = 1'b1;
        end else if (lvl[u][c] && !k && run[u][c] == D + 1) begin
          r[c] = 1'b1; lvl[u][c] = 1'b0;
        end else if (lvl[u][c] && k && prevk[u][c] && rd != 0) begin
          held[u][c]++;
          target = first[u][c] ? rd : RP;
          if (held[u][c] == target) begin
            p[c] = 1'b1; held[u][c] = 0; first[u][c] = 1'b0;
          end
        end
        prevk[u][c] = k;
      end
      if (p != 0 || r != 0) begin
        e.cyc = cyc; e.press = p; e.rel = r;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_unit(input int u, input logic [1:0] lv, input logic [1:0] pr,
                            input logic [1:0] rl);
    logic [1:0] el;
    ev_t e;
    bit have;
    el = {lvl[u][1], lvl[u][0]};
    total++;
    if (lv !== el) begin
      bad++;
      $display("FAIL level u%0d cyc=%0d got=%b want=%b", u, cyc, lv, el);
    end
    have = 1'b0;
    if (u == 0) begin
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      total++;
      if (e.cyc != cyc || e.press !== pr || e.rel !== rl) begin
        bad++;
        $display("FAIL event u%0d cyc=%0d got press=%b rel=%b want cyc=%0d press=%b rel=%b",
                 u, cyc, pr, rl, e.cyc, e.press, e.rel);
      end else begin
        $display("event u%0d cyc=%0d press=%b rel=%b ok", u, cyc, pr, rl);
      end
    end else if (pr != 0 || rl != 0) begin
      total++;
      bad++;
      $display("FAIL spurious u%0d cyc=%0d got press=%b rel=%b want none", u, cyc, pr, rl);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      check_unit(0, lvl_a, prs_a, rel_a);
      check_unit(1, lvl_b, prs_b, rel_b);
      if (done) break;
    end
    total++;
    if (q0.size() != 0) begin
      bad++;
      $display("FAIL leftover u0 got=%0d pending want=0", q0.size());
    end
    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL leftover u1 got=%0d pending want=0", q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; holds the raw key vector for n cycles.
  task automatic drive(input logic [1:0] v, input int n);
    keys = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int len;
    logic [1:0] v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 2);
    // clean press with repeats, then release
    drive(2'b10, 30);
    drive(2'b11, 12);
    // press bounce: 1, 2, 3 cycle lows separated by 2-cycle highs
    drive(2'b10, 1); drive(2'b11, 2);
    drive(2'b10, 2); drive(2'b11, 2);
    drive(2'b10, 3); drive(2'b11, 10);
    // release bounce while held
    drive(2'b10, 12); drive(2'b11, 2); drive(2'b10, 20);
    drive(2'b11, 12);
    // both keys together, independent releases
    drive(2'b00, 10); drive(2'b01, 8); drive(2'b11, 12);
    // reset during the repeat phase with the key still held
    drive(2'b10, 20);
    pulse_reset();
    drive(2'b10, 20);
    drive(2'b11, 12);
    // long hold on key 1
    drive(2'b01, 100);
    drive(2'b11, 12);
    // randomized mix of glitches and long holds
    for (int i = 0; i < 80; i++) begin
      v   = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 7);
      drive(v, len);
    end
    drive(2'b11, 15);
    done = 1'b1;
  end

endmodule
